// File: rtl/acc_drain_if.sv
// Output stream of the accumulator drain: one requantized element per transfer.
interface acc_drain_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [IW-1:0] out_index;
  logic          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/acc_drain.sv
// Captures N MAC accumulators on start, clears the MACs on the same edge, then
// streams the requantized (round half up, saturated to int8) elements out.
module acc_drain #(
  parameter int unsigned N = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [32*N-1:0] i_acc_in,
  input  logic [4:0]      i_shift,
  output logic            o_mac_clear,
  output logic            o_busy,
  acc_drain_if.master     out_if
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {StIdle, StDrain} state_e;

  state_e             r_state;
  logic [IW-1:0]      r_index;
  logic [4:0]         r_shift;
  logic signed [31:0] r_acc [N];

  logic               w_valid;
  logic               w_ready;
  logic               w_last_idx;
  logic signed [32:0] w_acc;
  logic signed [32:0] w_bias;
  logic signed [32:0] w_sum;
  logic signed [32:0] w_r;
  logic [7:0]         w_sat;

  assign w_valid    = (r_state == StDrain);
  assign w_ready    = out_if.out_ready;
  assign w_last_idx = (r_index == IW'(N - 1));

  // MACs zero on the capture edge, so the clear is combinational with start.
  assign o_mac_clear = i_start && (r_state == StIdle);
  assign o_busy      = w_valid;

  assign out_if.out_valid = w_valid;
  assign out_if.out_index = r_index;
  assign out_if.out_last  = w_last_idx && w_valid;
  assign out_if.out_data  = w_valid ? w_sat : 8'h00;

  // Requantize the selected element; 33 bits keep the rounding bias from overflowing.
  always_comb begin
    w_acc  = {r_acc[r_index][31], r_acc[r_index]};
    w_bias = '0;
    if (r_shift != 5'd0) begin
      w_bias = 33'sd1 <<< (r_shift - 5'd1);
    end
    w_sum = w_acc + w_bias;
    w_r   = w_sum >>> r_shift;
    if (w_r > 33'sd127) begin
      w_sat = 8'h7f;
    end else if (w_r < -33'sd128) begin
      w_sat = 8'h80;
    end else begin
      w_sat = w_r[7:0];
    end
  end

  // Capture/drain controller; reset wins over start and discards captured data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_index <= '0;
      r_shift <= '0;
      for (int i = 0; i < int'(N); i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            for (int i = 0; i < int'(N); i++) begin
              r_acc[i] <= i_acc_in[32*i +: 32];
            end
            r_shift <= i_shift;
            r_index <= '0;
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_ready) begin
            if (w_last_idx) begin
              r_index <= '0;
              r_state <= StIdle;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_drain.sv
// Directed and randomized bench for acc_drain with an arithmetic reference model.
module tb_acc_drain;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic            clk;
  logic            rst;
  logic            start;
  logic [32*N-1:0] acc_in;
  logic [4:0]      shift;
  logic            mac_clear;
  logic            busy;

  acc_drain_if #(.N(N)) u_if ();

  acc_drain #(.N(N)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_acc_in    (acc_in),
    .i_shift     (shift),
    .o_mac_clear (mac_clear),
    .o_busy      (busy),
    .out_if      (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_fail;
  int n_chk;

  logic signed [31:0] m_next [N];
  logic signed [31:0] m_acc  [N];
  int                 m_sh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference requantizer: round half up, arithmetic shift, saturate to int8.
  function automatic logic [7:0] ref_q(input logic signed [31:0] a, input int s);
    longint v;
    longint r;
    v = longint'(a);
    if (s > 0) v = v + (longint'(1) << (s - 1));
    r = v >>> s;
    if (r > 127) return 8'h7f;
    if (r < -128) return 8'h80;
    return r[7:0];
  endfunction

  task automatic set4(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    m_next[0] = a;
    m_next[1] = b;
    m_next[2] = c;
    m_next[3] = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(u_if.out_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_last"},  32'(u_if.out_last), 32'd0);
    chk({tag, "_data"},  32'(u_if.out_data), 32'd0);
    chk({tag, "_index"}, 32'(u_if.out_index), 32'd0);
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1,...; 2: random ready.
  task automatic run_tile(input string tag, input int shamt, input int mode, input bit start_hold);
    int idx;
    int cyc;
    for (int i = 0; i < int'(N); i++) begin
      acc_in[32*i +: 32] = m_next[i];
      m_acc[i] = m_next[i];
    end
    shift = shamt[4:0];
    m_sh  = shamt;
    start = 1'b1;
    #1;
    chk({tag, "_clear_on_start"}, 32'(mac_clear), 32'd1);
    tick();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < int'(N) && cyc < 200) begin
      case (mode)
        0:       u_if.out_ready = 1'b1;
        1:       u_if.out_ready = (cyc % 3 == 0);
        default: u_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      start = start_hold ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < int'(N); i++) acc_in[32*i +: 32] = $urandom;
      shift = 5'($urandom);
      #1;
      chk({tag, "_valid"}, 32'(u_if.out_valid), 32'd1);
      chk({tag, "_busy"},  32'(busy), 32'd1);
      chk({tag, "_index"}, 32'(u_if.out_index), 32'(idx));
      chk({tag, "_last"},  32'(u_if.out_last), 32'(idx == int'(N) - 1));
      chk({tag, "_data"},  32'(u_if.out_data), 32'(ref_q(m_acc[idx], m_sh)));
      chk({tag, "_no_clear"}, 32'(mac_clear), 32'd0);
      tick();
      if (u_if.out_ready) idx++;
      cyc++;
    end
    chk({tag, "_transfers"}, 32'(idx), 32'(N));
    start = 1'b0;
    u_if.out_ready = 1'b0;
    #1;
    chk_idle({tag, "_after"});
  endtask

  initial begin
    n_pass = 0;
    n_fail = 0;
    n_chk  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    acc_in = '0;
    shift  = '0;
    u_if.out_ready = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_clear", 32'(mac_clear), 32'd0);
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    set4(32'd100, -32'sd100, 32'd8, -32'sd9);
    run_tile("round", 4, 0, 1'b0);
    // Literal cross-check of the rounding example.
    chk("round_lit0", 32'(ref_q(32'd100, 4)), 32'h06);
    chk("round_lit3", 32'(ref_q(-32'sd9, 4)), 32'hff);

    set4(32'd1000000, -32'sd1000000, 32'd127, -32'sd128);
    run_tile("sat", 0, 0, 1'b0);

    set4(32'h7fffffff, 32'h80000000, 32'd0, 32'hffffffff);
    run_tile("extreme", 31, 0, 1'b0);

    set4(32'd500, -32'sd77, 32'd3, 32'd40000);
    run_tile("backpr", 2, 1, 1'b1);
    // Start immediately in the first IDLE cycle must be accepted.
    set4(32'd64, -32'sd64, 32'd31, -32'sd33);
    run_tile("restart", 3, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < int'(N); i++) begin
        m_next[i] = (t % 2 == 0) ? 32'($urandom_range(0, 4000)) - 32'd2000 : $urandom;
      end
      run_tile("rand", int'($urandom_range(0, 31)), 2, 1'b0);
    end

    // Reset in the middle of a drain.
    set4(32'd10, 32'd20, 32'd30, 32'd40);
    for (int i = 0; i < int'(N); i++) acc_in[32*i +: 32] = m_next[i];
    shift = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    u_if.out_ready = 1'b1;
    tick();
    tick();
    chk("mid_index2", 32'(u_if.out_index), 32'd2);
    rst   = 1'b1;
    start = 1'b1;
    #1;
    chk("mid_rst_no_clear", 32'(mac_clear), 32'd0);
    tick();
    chk_idle("mid_rst");
    chk("mid_rst_clear_idle", 32'(mac_clear), 32'd1);
    tick();
    chk_idle("rst_start_ignored");
    rst   = 1'b0;
    start = 1'b0;
    u_if.out_ready = 1'b0;
    tick();
    chk_idle("rst_released");
    set4(-32'sd300, 32'd300, 32'd5, -32'sd6);
    run_tile("fresh", 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
